// File: rtl/mem_line_responder_pkg.sv
// Shared types and geometry for the line-organised memory responder.
// Request/response structs plus the line-offset helper used for address splitting.
package mem_line_responder_pkg;

    localparam int unsigned PA_WIDTH   = 32;
    localparam int unsigned REG_WIDTH  = 32;
    localparam int unsigned LINE_WIDTH = 128;
    localparam int unsigned ID_WIDTH   = 4;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    typedef struct packed {
        req_kind_e             write;
        logic [PA_WIDTH-1:0]   addr;
        logic [REG_WIDTH-1:0]  data;
    } mem_req_t;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } mem_resp_t;

    function automatic int unsigned line_off_bits(input int unsigned line_width);
        return $clog2(line_width / 8);
    endfunction

    localparam int unsigned LINE_OFF_BITS = line_off_bits(LINE_WIDTH);
    localparam int unsigned LINE_WORDS    = LINE_WIDTH / REG_WIDTH;

endpackage

// File: rtl/mem_line_responder_if.sv
// Request/response bus between the dme memory port (master) and the responder (slave).
interface mem_line_responder_if;
    import mem_line_responder_pkg::*;

    logic                  i_req_valid;
    logic                  i_req_write;
    logic [PA_WIDTH-1:0]   i_req_addr;
    logic [REG_WIDTH-1:0]  i_req_data;
    logic                  o_req_ready;
    logic [ID_WIDTH-1:0]   o_req_id;
    logic                  o_resp_valid;
    logic [LINE_WIDTH-1:0] o_resp_data;
    logic [ID_WIDTH-1:0]   o_resp_id;
    logic                  i_resp_ack;

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_data, i_resp_ack,
        input  o_req_ready, o_req_id, o_resp_valid, o_resp_data, o_resp_id
    );

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_data, i_resp_ack,
        output o_req_ready, o_req_id, o_resp_valid, o_resp_data, o_resp_id
    );

endinterface

// File: rtl/mem_line_responder_resp_queue.sv
// In-order FIFO of pending read responses; every slot counts down its latency in parallel.
// The head is presentable once its countdown has reached zero.
module mem_line_responder_resp_queue
    import mem_line_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  mem_resp_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output logic      head_done,
    output mem_resp_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    mem_resp_t        slot [DEPTH];
    logic [CNT_W-1:0] cnt  [DEPTH];

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head      = slot[rd_ptr[PTR_W-1:0]];
    assign head_done = (cnt[rd_ptr[PTR_W-1:0]] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            if (push) begin
                slot[wr_ptr[PTR_W-1:0]] <= push_entry;
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            // Idle slots also count down; harmless since a push reloads the counter.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr[PTR_W-1:0] == PTR_W'(i))) begin
                    cnt[i] <= CNT_W'(LATENCY - 1);
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory responder for the dme port: word stores into a line array, tagged line reads
// returned in order after a fixed latency. Optional counters under MEM_LINE_RESP_STATS_EN.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int unsigned MEM_LINES   = 256,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_line_responder_if.slave  bus
`ifdef MEM_LINE_RESP_STATS_EN
    ,
    output logic [31:0]          o_rd_count,
    output logic [31:0]          o_wr_count
`endif
);

    localparam int unsigned IDX_BITS  = $clog2(MEM_LINES);
    localparam int unsigned WORD_BITS = $clog2(LINE_WORDS);

    mem_req_t                           req;
    logic [IDX_BITS-1:0]                line_idx;
    logic [WORD_BITS-1:0]               word_sel;
    logic [LINE_WORDS-1:0][REG_WIDTH-1:0] mem [MEM_LINES];
    logic                               q_full;
    logic                               q_empty;
    logic                               head_done;
    logic                               head_ready;
    logic                               accept;
    logic                               do_read;
    logic                               do_write;
    logic                               pop;
    mem_resp_t                          push_entry;
    mem_resp_t                          head;
    logic [ID_WIDTH-1:0]                id_cnt;
    logic                               unused_addr_bits;

    assign req = '{write: req_kind_e'(bus.i_req_write),
                   addr:  bus.i_req_addr,
                   data:  bus.i_req_data};

    assign line_idx         = req.addr[LINE_OFF_BITS +: IDX_BITS];
    assign word_sel         = req.addr[2 +: WORD_BITS];
    assign unused_addr_bits = ^{req.addr[PA_WIDTH-1:LINE_OFF_BITS+IDX_BITS], req.addr[1:0]};

    // Ready is held low during reset so no request can be taken while state is cleared.
    assign bus.o_req_ready = rst && !q_full;
    assign accept          = bus.i_req_valid && bus.o_req_ready;
    assign do_write        = accept && (req.write == REQ_WRITE);
    assign do_read         = accept && (req.write == REQ_READ);

    assign head_ready = !q_empty && head_done;
    assign pop        = head_ready && bus.i_resp_ack;

    assign bus.o_req_id     = id_cnt;
    assign bus.o_resp_valid = head_ready;
    assign bus.o_resp_data  = head_ready ? head.data : '0;
    assign bus.o_resp_id    = head_ready ? head.id   : '0;

    assign push_entry = '{data: mem[line_idx], id: id_cnt};

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[line_idx][word_sel] <= req.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_cnt <= '0;
        end else if (do_read) begin
            id_cnt <= id_cnt + ID_WIDTH'(1);
        end
    end

    mem_line_responder_resp_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .LATENCY (LATENCY)
    ) u_resp_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (do_read),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (q_full),
        .empty      (q_empty),
        .head_done  (head_done),
        .head       (head)
    );

`ifdef MEM_LINE_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rd_count <= '0;
            o_wr_count <= '0;
        end else begin
            if (do_read)  o_rd_count <= o_rd_count + 32'd1;
            if (do_write) o_wr_count <= o_wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: queue-based response model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_line_responder;
    import mem_line_responder_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_line_responder_if bus();
`ifdef MEM_LINE_RESP_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    mem_line_responder #(
        .MEM_LINES   (256),
        .QUEUE_DEPTH (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_LINE_RESP_STATS_EN
        ,
        .o_rd_count (rd_count),
        .o_wr_count (wr_count)
`endif
    );

    typedef struct {
        logic [127:0] data;
        logic [3:0]   id;
        int unsigned  due;
    } exp_t;

    exp_t         q[$];
    logic [127:0] mmem [256];
    int unsigned  cyc = 0;
    logic [3:0]   next_id = '0;
    int unsigned  m_rd = 0;
    int unsigned  m_wr = 0;
    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return rst && (q.size() < DEPTH);
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) && (cyc >= q[0].due);
    endfunction

    // Advance the model by one rising edge using the inputs presented in that cycle.
    task automatic model_edge();
        bit          rdy;
        bit          vld;
        int unsigned line;
        int unsigned word;
        rdy = m_ready();
        vld = m_valid();
        cyc++;
        if (!rst) begin
            q.delete();
            next_id = '0;
            m_rd = 0;
            m_wr = 0;
        end else begin
            if (vld && bus.i_resp_ack) void'(q.pop_front());
            if (bus.i_req_valid && rdy) begin
                line = (bus.i_req_addr >> 4) % 256;
                word = (bus.i_req_addr >> 2) % 4;
                if (bus.i_req_write) begin
                    mmem[line][word*32 +: 32] = bus.i_req_data;
                    m_wr++;
                end else begin
                    q.push_back('{data: mmem[line], id: next_id, due: cyc + LAT - 1});
                    next_id = next_id + 4'd1;
                    m_rd++;
                end
            end
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge happen, return at next falling edge.
    task automatic tick(input bit v, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit ack, input bit r);
        #1;
        bus.i_req_valid = v;
        bus.i_req_write = w;
        bus.i_req_addr  = a;
        bus.i_req_data  = d;
        bus.i_resp_ack  = ack;
        rst             = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input bit ack);
        tick(1'b0, 1'b0, 32'h0, 32'h0, ack, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input bit ack);
        tick(1'b1, 1'b0, a, 32'h0, ack, 1'b1);
    endtask

    task automatic reset_pulse();
        tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) idle(1'b1);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d responses still pending, required 0", q.size());
        end
    endtask

    always @(negedge clk) begin
        chk("req_ready", {127'b0, bus.o_req_ready}, {127'b0, m_ready()});
        chk("req_id", {124'b0, bus.o_req_id}, {124'b0, next_id});
        chk("resp_valid", {127'b0, bus.o_resp_valid}, {127'b0, m_valid()});
        if (m_valid()) begin
            chk("resp_data", bus.o_resp_data, q[0].data);
            chk("resp_id", {124'b0, bus.o_resp_id}, {124'b0, q[0].id});
        end
`ifdef MEM_LINE_RESP_STATS_EN
        chk("rd_count", {96'b0, rd_count}, {96'b0, m_rd});
        chk("wr_count", {96'b0, wr_count}, {96'b0, m_wr});
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int unsigned acc;
        int unsigned guard;

        for (int i = 0; i < 256; i++) mmem[i] = '0;
        bus.i_req_valid = 1'b0;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_data  = '0;
        bus.i_resp_ack  = 1'b0;
        @(negedge clk);
        reset_pulse();
        reset_pulse();
        chk("rst_ready", {127'b0, bus.o_req_ready}, 128'd0);
        chk("rst_valid", {127'b0, bus.o_resp_valid}, 128'd0);
        chk("rst_id", {124'b0, bus.o_req_id}, 128'd0);

        // Known contents for lines 0..7: word w of line i holds i*16+w.
        for (int i = 0; i < 8; i++)
            for (int w = 0; w < 4; w++)
                tick(1'b1, 1'b1, 32'(i*16 + w*4), 32'(i*16 + w), 1'b0, 1'b1);

        // Reset discards an in-flight read
        rd(32'h8000, 1'b0);
        idle(1'b0);
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            chk("t1_no_resp", {127'b0, bus.o_resp_valid}, 128'd0);
            idle(1'b0);
        end

        // Store then read sees the store
        tick(1'b1, 1'b1, 32'h8004, 32'hDEADBEEF, 1'b0, 1'b1);
        chk("t2_req_id", {124'b0, bus.o_req_id}, 128'd0);
        rd(32'h8000, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("t2_early", {127'b0, bus.o_resp_valid}, 128'd0);
        idle(1'b0);
        chk("t2_valid", {127'b0, bus.o_resp_valid}, 128'd1);
        chk("t2_word1", {96'b0, bus.o_resp_data[63:32]}, {96'b0, 32'hDEADBEEF});
        chk("t2_word0", {96'b0, bus.o_resp_data[31:0]}, 128'd0);
        chk("t2_id", {124'b0, bus.o_resp_id}, 128'd0);
        chk("t2_model", {96'b0, q[0].data[63:32]}, {96'b0, 32'hDEADBEEF});
        idle(1'b1);

        // A later store does not affect an accepted read
        rd(32'h8000, 1'b0);
        tick(1'b1, 1'b1, 32'h8000, 32'h12345678, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("t3_valid", {127'b0, bus.o_resp_valid}, 128'd1);
        chk("t3_old_word", {96'b0, bus.o_resp_data[31:0]}, 128'd0);
        chk("t3_id", {124'b0, bus.o_resp_id}, 128'd1);
        idle(1'b1);
        rd(32'h8000, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("t3_new_word", {96'b0, bus.o_resp_data[31:0]}, {96'b0, 32'h12345678});
        idle(1'b1);

        // Full queue holds off a fifth request until after the first ack
        reset_pulse();
        for (int i = 0; i < 4; i++) rd(32'(i*16), 1'b0);
        chk("t4_full", {127'b0, bus.o_req_ready}, 128'd0);
        chk("t4_head_valid", {127'b0, bus.o_resp_valid}, 128'd1);
        for (int i = 0; i < 2; i++) begin
            rd(32'h8010, 1'b0);
            chk("t4_held", {127'b0, bus.o_req_ready}, 128'd0);
        end
        chk("t4_order0", {124'b0, bus.o_resp_id}, 128'd0);
        rd(32'h8010, 1'b1);
        chk("t4_ready_after_ack", {127'b0, bus.o_req_ready}, 128'd1);
        chk("t4_fifth_id", {124'b0, bus.o_req_id}, 128'd4);
        chk("t4_order1", {124'b0, bus.o_resp_id}, 128'd1);
        rd(32'h8010, 1'b1);
        chk("t4_order2", {124'b0, bus.o_resp_id}, 128'd2);
        idle(1'b1);
        chk("t4_order3", {124'b0, bus.o_resp_id}, 128'd3);
        idle(1'b1);
        drain();

        // Backpressure holds the head; continuous ack gives back-to-back responses
        reset_pulse();
        for (int i = 0; i < 4; i++) rd(32'((i + 2) * 16), 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_valid", {127'b0, bus.o_resp_valid}, 128'd1);
            chk("t5_hold_id", {124'b0, bus.o_resp_id}, 128'd0);
            chk("t5_hold_data", bus.o_resp_data,
                {32'h00000023, 32'h00000022, 32'h00000021, 32'h00000020});
            idle(1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("t5_b2b_valid", {127'b0, bus.o_resp_valid}, 128'd1);
            chk("t5_b2b_id", {124'b0, bus.o_resp_id}, 128'(i));
            idle(1'b1);
        end
        chk("t5_empty", {127'b0, bus.o_resp_valid}, 128'd0);

        // ID wrap over 17 reads
        reset_pulse();
        acc = 0;
        guard = 0;
        while (acc < 17 && guard < 200) begin
            guard++;
            if (bus.o_req_ready) begin
                chk("t6_id", {124'b0, bus.o_req_id}, 128'(acc % 16));
                a = $urandom;
                a[11:4] = 8'($urandom_range(0, 7));
                rd(a, 1'b1);
                acc++;
            end else begin
                idle(1'b1);
            end
        end
        if (acc < 17) begin
            n_checks++;
            n_fail++;
            $display("FAIL t6_accepts: got %0d reads accepted, required 17", acc);
        end
`ifdef MEM_LINE_RESP_STATS_EN
        chk("t6_rd_count", {96'b0, rd_count}, 128'd17);
`endif
        drain();

        // Randomized traffic with aliased upper address bits
        for (int i = 0; i < 800; i++) begin
            a = $urandom;
            a[11:4] = 8'($urandom_range(0, 7));
            tick($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, a, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
